// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: loads are a read followed by lane extraction,
// sub-word stores are read-modify-write, over a single-port sync-read RAM.
module dmem_access_ctrl #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_access,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic        busy
);
    localparam logic [3:0] LD_B  = 4'h0;
    localparam logic [3:0] LD_H  = 4'h1;
    localparam logic [3:0] LD_W  = 4'h2;
    localparam logic [3:0] LD_BU = 4'h4;
    localparam logic [3:0] LD_HU = 4'h5;
    localparam logic [3:0] ST_B  = 4'h8;
    localparam logic [3:0] ST_H  = 4'h9;
    localparam logic [3:0] ST_W  = 4'hA;
    localparam logic [2:0] RD_LAT_W = 3'(RD_LAT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_MERGE = 3'd3,
        S_WRITE = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t      state_r, state_s;
    logic [2:0]  cnt_r, cnt_s;
    logic [31:0] addr_r, wdata_r, rdata_r, rdata_s;
    logic [3:0]  access_r;
    logic        err_r, err_s, accept_s, sub_store_s;
    logic [31:0] word_addr_s;

    function automatic logic access_err(input logic [3:0] acc, input logic [1:0] off);
        logic err;
        case (acc)
            LD_B, LD_BU, ST_B: err = 1'b0;
            LD_H, LD_HU, ST_H: err = off[0];
            LD_W, ST_W:        err = (off != 2'b00);
            default:           err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [31:0] load_extract(input logic [3:0] acc, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (acc)
            LD_B:    r = {{24{b[7]}}, b};
            LD_BU:   r = {24'h000000, b};
            LD_H:    r = {{16{h[15]}}, h};
            LD_HU:   r = {16'h0000, h};
            LD_W:    r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [3:0] acc, input logic [1:0] off,
                                                input logic [31:0] word, input logic [31:0] wd);
        logic [31:0] r;
        r = word;
        case (acc)
            ST_B: begin
                case (off)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    default: r[31:24] = wd[7:0];
                endcase
            end
            ST_H: begin
                if (off[1]) begin
                    r[31:16] = wd[15:0];
                end else begin
                    r[15:0] = wd[15:0];
                end
            end
            default: r = word;
        endcase
        return r;
    endfunction

    assign accept_s    = (state_r == S_IDLE) && req_valid;
    assign sub_store_s = (access_r == ST_B) || (access_r == ST_H);
    assign word_addr_s = {addr_r[31:2], 2'b00};

    // State, wait counter, response and latched request registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= S_IDLE;
            cnt_r    <= 3'd0;
            addr_r   <= 32'h0000_0000;
            access_r <= 4'h0;
            wdata_r  <= 32'h0000_0000;
            rdata_r  <= 32'h0000_0000;
            err_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            rdata_r <= rdata_s;
            err_r   <= err_s;
            if (accept_s) begin
                addr_r   <= req_addr;
                access_r <= req_access;
                wdata_r  <= req_wdata;
            end else begin
                addr_r   <= addr_r;
                access_r <= access_r;
                wdata_r  <= wdata_r;
            end
        end
    end

    // Next-state, wait countdown and response capture
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        rdata_s = rdata_r;
        err_s   = err_r;
        case (state_r)
            S_IDLE: begin
                if (req_valid) begin
                    rdata_s = 32'h0000_0000;
                    cnt_s   = 3'd0;
                    err_s   = access_err(req_access, req_addr[1:0]);
                    if (err_s) begin
                        state_s = S_RESP;
                    end else if (req_access == ST_W) begin
                        state_s = S_WRITE;
                    end else begin
                        state_s = S_READ;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_READ: begin
                if (RD_LAT_W <= 3'd1) begin
                    state_s = S_MERGE;
                end else begin
                    state_s = S_WAIT;
                    cnt_s   = RD_LAT_W - 3'd1;
                end
            end
            S_WAIT: begin
                if (cnt_r <= 3'd1) begin
                    state_s = S_MERGE;
                    cnt_s   = 3'd0;
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            S_MERGE: begin
                state_s = S_RESP;
                if (sub_store_s) begin
                    rdata_s = 32'h0000_0000;
                end else begin
                    rdata_s = load_extract(access_r, addr_r[1:0], mem_rdata);
                end
            end
            S_WRITE: state_s = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_RESP;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Output decode from registered state; an async reset drops strobes at once
    always_comb begin
        req_ready  = 1'b0;
        busy       = 1'b1;
        resp_valid = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'h0000_0000;
        mem_wdata  = 32'h0000_0000;
        case (state_r)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_READ: begin
                mem_re   = 1'b1;
                mem_addr = word_addr_s;
            end
            S_WAIT: mem_addr = word_addr_s;
            S_MERGE: begin
                mem_addr = word_addr_s;
                if (sub_store_s) begin
                    mem_we    = 1'b1;
                    mem_wdata = store_merge(access_r, addr_r[1:0], mem_rdata, wdata_r);
                end else begin
                    mem_we = 1'b0;
                end
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = word_addr_s;
                mem_wdata = wdata_r;
            end
            S_RESP: resp_valid = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign resp_rdata = rdata_r;
    assign resp_err   = err_r;

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequences every data-memory access from the MEM stage over a single-port, synchronous-read, word-wide data RAM. Loads are handled as read, then byte/half extraction. Sub-word stores are handled as read-modify-write. Misaligned or illegal accesses are flagged without touching memory. The block holds off the pipeline through a valid/ready request/response handshake.

Parameters:
RD_LAT, 1, cycles from mem_re assertion to valid mem_rdata; legal range 1..4.

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
req_valid  in  1  access request present
req_ready  out  1  controller can accept a request
req_addr  in  32  byte address
req_access  in  4  access type code from the shared dmem type header (LD_B, LD_H, LD_W, LD_BU, LD_HU, ST_B, ST_H, ST_W)
req_wdata  in  32  store data; low byte/half used for ST_B/ST_H
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  extended load result; 0 for stores and errors
resp_err  out  1  misaligned or illegal access
mem_addr  out  32  word address {addr[31:2],2'b00}
mem_re  out  1  RAM read strobe
mem_rdata  in  32  RAM read data
mem_we  out  1  RAM full-word write strobe
mem_wdata  out  32  RAM write data
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rstn=0): state IDLE; wait counter 0; latched regs 0. Outputs: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
- All outputs are decoded from registered state, so an asserted reset drops mem_we/mem_re in the same cycle.
- States: IDLE, READ, WAIT, MERGE, WRITE, RESP.
- IDLE: req_ready=1.
  - On req_valid, latch addr, access and wdata at the edge.
  - Error (illegal code, half with addr[0]=1, word with addr[1:0]!=0) -> RESP with err=1, rdata=0, no RAM strobe.
  - ST_W -> WRITE.
  - Other legal codes -> READ.
- READ: mem_re=1 for exactly one cycle. If RD_LAT=1 -> MERGE, else -> WAIT with counter=RD_LAT-1.
- WAIT: decrement the counter each cycle; at 1 -> MERGE.
- MERGE (mem_rdata valid this cycle):
  - Loads: select the byte/half by addr[1:0], sign- or zero-extend, register into resp_rdata -> RESP.
  - ST_B/ST_H: mem_we=1, mem_wdata = mem_rdata with the addressed lane replaced by wdata[7:0]/[15:0] -> RESP.
- WRITE: mem_we=1, mem_wdata=wdata -> RESP.
- RESP: resp_valid=1 held, with rdata/err stable, until resp_ready=1 -> IDLE.
- No overlap: req_ready=0 outside IDLE, so a new request is accepted at earliest the cycle after the response handshake.
- mem_addr is held constant from READ/WRITE through MERGE; it is 0 in IDLE and RESP.
- Latency, request edge to resp_valid (RD_LAT=1): 3 cycles for load/sub-word store, 2 for ST_W, 1 for error.
- mem_we is asserted at most once per request. It is never asserted for loads or errors.
- resp_rdata=0 for every store.

Test Plan:
- RAM[0x100]=0x8899AABB, RD_LAT=1, LD_B @0x101 -> mem_re in cycle 1, resp_valid in cycle 3, rdata=0xFFFFFFAA, err=0.
- Same word, LD_HU @0x102 -> rdata=0x00008899; LD_H @0x102 -> 0xFFFF8899.
- ST_B @0x103, wdata=0x12345678 -> mem_we one cycle, mem_wdata=0x7899AABB, mem_addr=0x100; a readback LD_W @0x100 returns 0x7899AABB.
- LD_W @0x102 and ST_H @0x101 -> resp_valid the cycle after acceptance, err=1, rdata=0, mem_re/mem_we never asserted.
- RD_LAT=3, ST_H @0x102 wdata=0xCAFE on 0x8899AABB -> 2 WAIT cycles, then mem_wdata=0xCAFEAABB. Separately, ST_W @0x104 0xDEADBEEF -> write in cycle 1, no read.
- resp_ready held low 4 cycles -> resp_valid and rdata stable, req_ready=0. Separately, rstn pulsed low in MERGE of a store -> mem_we drops immediately, busy=0, and the next request completes normally.
